board_sim_ctrl: RTL and testbench
=================================

# board_sim_ctrl

Simulation-board supervisor for multi-channel DDR3 FPGA test benches. It sequences the memory-model reset and waits for per-channel calibration before releasing the DUT harness reset. It then watches the harness success/fail signals and per-channel calibration health, and reports a registered pass/fail verdict with a cause code and a run-cycle count. It sits at board level between the FPGA test-harness instance and N onboard DDR3 models, replacing ad-hoc force statements with deterministic sequencing.

## Interface
Parameters:
- NUM_CHANNELS, 1, number of DDR3 channels/models (1–8)
- RESET_HOLD_CYCLES, 16, cycles `ddr_sys_rst_n` is held low after reset release (≥1)
- CALIB_TIMEOUT, 50000, max cycles in calibration wait; 0 disables the timeout
- RUN_TIMEOUT, 1000000, max cycles in run; 0 disables the timeout
- CNT_W, 32, width of the cycle counters

Ports:
- clock  in  1  single board clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- calib_done  in  NUM_CHANNELS  per-channel init_calib_complete from the harness MIG islands
- dut_success  in  1  harness success indication (level)
- dut_fail  in  1  harness failure indication (level)
- ddr_sys_rst_n  out  NUM_CHANNELS  active-low reset to each DDR3 model
- dut_reset  out  1  active-high reset to the FPGA test harness
- io_success  out  1  sticky pass
- io_fail  out  1  sticky fail
- io_done  out  1  io_success | io_fail, registered
- status  out  3  cause code (package enum)
- run_cycles  out  CNT_W  cycles spent in S_RUN

## Operation
- FSM states: S_RESET, S_MEM_RST, S_CALIB, S_RUN, S_PASS, S_FAIL.
- Reset values: state S_RESET; `dut_reset`=1; `ddr_sys_rst_n`=0 on all channels; `io_success`=`io_fail`=`io_done`=0; `status`=ST_BUSY(0); `run_cycles`=0; all counters 0.
- S_RESET → S_MEM_RST on the first edge with reset low.
- S_MEM_RST: the hold counter increments. At count RESET_HOLD_CYCLES → S_CALIB, and `ddr_sys_rst_n` goes all-ones.
- S_CALIB:
  - Each channel latches calib_done into a sticky seen bit.
  - All seen → S_RUN, and `dut_reset` goes to 0.
  - Timeout counter reaches CALIB_TIMEOUT (nonzero) with any channel unseen → S_FAIL, ST_CALIB_TIMEOUT.
- S_RUN: `run_cycles` increments each cycle, saturating at all-ones. Priority per cycle, highest first:
  - `dut_fail` → S_FAIL, ST_DUT_FAIL
  - any live `calib_done` low → S_FAIL, ST_CALIB_LOST
  - `dut_success` → S_PASS, ST_PASS
  - run counter equals RUN_TIMEOUT (nonzero) → S_FAIL, ST_RUN_TIMEOUT
- S_PASS / S_FAIL:
  - Terminal; only reset leaves them.
  - `dut_reset` stays 0; `run_cycles` and `status` are frozen.
  - Further dut_* inputs are ignored.
- Reset mid-operation: all state returns to reset values on the next edge, including `dut_reset`=1 and `ddr_sys_rst_n`=0.
- Status codes: 0 BUSY, 1 PASS, 2 DUT_FAIL, 3 CALIB_TIMEOUT, 4 CALIB_LOST, 5 RUN_TIMEOUT.

## Timing
- All outputs are registered; no combinational input-to-output path.
- `ddr_sys_rst_n` rises RESET_HOLD_CYCLES+1 edges after the first edge with reset low.
- `dut_reset` falls on the edge after the last channel's calib_done is sampled high. Channels may rise in any order or in the same cycle.
- Verdict latency is one edge: the event is sampled at edge k, and `io_*` and `status` are valid after edge k.
- `io_done` asserts in the same cycle as `io_success`/`io_fail`.
- Terminal `run_cycles` equals the number of edges spent in S_RUN, including the decision edge.

## Configuration
- `BOARD_SIM_CALIB_BYPASS_EN` defined:
  - S_CALIB is compiled out; S_MEM_RST goes directly to S_RUN.
  - `calib_done` is ignored; ST_CALIB_TIMEOUT and ST_CALIB_LOST are never produced.
  - Used for fast runs with calibration-stubbed models.
- Undefined: full behaviour as in Operation.

## Structure
- Package `board_sim_pkg`:
  - state enum `board_sim_state_e`
  - status enum `board_sim_status_e` (3-bit)
  - constant `BOARD_SIM_MAX_CHANNELS`=8
- Sub-module `board_calib_tracker`, one per channel, generated over NUM_CHANNELS:
  - sticky seen bit, cleared by reset
  - `lost` flag, valid only while armed in S_RUN
- The top level holds the FSM, the hold/timeout/run counters and the output registers.

## Test plan
- NUM_CHANNELS=2; calib_done[0] at S_CALIB entry+10, [1] at +40; dut_success 100 cycles later → `dut_reset` falls after edge 41, io_success=1, status=1, run_cycles=101.
- CALIB_TIMEOUT=64; channel 1 never calibrates → io_fail after 64 cycles in S_CALIB, status=3, `dut_reset` still 1.
- In S_RUN, calib_done[0] drops for one cycle → io_fail, status=4, run_cycles frozen.
- dut_success and dut_fail high in the same cycle → io_fail=1, io_success=0, status=2.
- RUN_TIMEOUT=200 with no harness response → fail at run_cycles=200, status=5; then assert reset mid-run on a new test → all outputs return to reset values next edge.
- With BOARD_SIM_CALIB_BYPASS_EN and calib_done=0 → S_RUN is entered RESET_HOLD_CYCLES+2 edges after reset release; dut_success → status=1.

Source files
------------

// File: rtl/board_sim_pkg.sv
// board_sim_pkg: shared types for the DDR3 simulation-board supervisor.
// Optional build macro used by this slice: BOARD_SIM_CALIB_BYPASS_EN.
package board_sim_pkg;

  localparam int BOARD_SIM_MAX_CHANNELS = 8;

  typedef enum logic [2:0] {
    S_RESET,
    S_MEM_RST,
    S_CALIB,
    S_RUN,
    S_PASS,
    S_FAIL
  } board_sim_state_e;

  typedef enum logic [2:0] {
    ST_BUSY          = 3'd0,
    ST_PASS          = 3'd1,
    ST_DUT_FAIL      = 3'd2,
    ST_CALIB_TIMEOUT = 3'd3,
    ST_CALIB_LOST    = 3'd4,
    ST_RUN_TIMEOUT   = 3'd5
  } board_sim_status_e;

endpackage

// File: rtl/board_calib_tracker.sv
// board_calib_tracker: per-channel calibration watch.
// Sticky seen bit during calibration, live loss flag during run.
module board_calib_tracker (
  input  logic clock,
  input  logic reset,
  input  logic arm_calib,
  input  logic arm_run,
  input  logic calib_done,
  output logic seen,
  output logic lost
);

  always_ff @(posedge clock) begin
    if (reset) begin
      seen <= 1'b0;
    end else if (arm_calib && calib_done) begin
      seen <= 1'b1;
    end
  end

  assign lost = arm_run & ~calib_done;

endmodule

// File: rtl/board_sim_ctrl.sv
// board_sim_ctrl: DDR3 model / harness reset sequencer and verdict register.
// Define BOARD_SIM_CALIB_BYPASS_EN to compile out calibration tracking.
module board_sim_ctrl
  import board_sim_pkg::*;
#(
  parameter int NUM_CHANNELS      = 1,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int CALIB_TIMEOUT     = 50000,
  parameter int RUN_TIMEOUT       = 1000000,
  parameter int CNT_W             = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] calib_done,
  input  logic                    dut_success,
  input  logic                    dut_fail,
  output logic [NUM_CHANNELS-1:0] ddr_sys_rst_n,
  output logic                    dut_reset,
  output logic                    io_success,
  output logic                    io_fail,
  output logic                    io_done,
  output logic [2:0]              status,
  output logic [CNT_W-1:0]        run_cycles
);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(RESET_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RUN_LIM    = CNT_W'(RUN_TIMEOUT);

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > BOARD_SIM_MAX_CHANNELS) begin : g_bad_cfg
    $error("board_sim_ctrl: NUM_CHANNELS out of range");
  end

  board_sim_state_e  state_q, state_d;
  board_sim_status_e status_q, status_d;
  logic [CNT_W-1:0]  hold_q, calib_q, run_q, run_nxt;
  logic              any_lost;

  assign run_nxt = (&run_q) ? run_q : run_q + 1'b1;

`ifndef BOARD_SIM_CALIB_BYPASS_EN
  logic [NUM_CHANNELS-1:0] seen, lost;
  logic                    all_seen;
  logic                    calib_arm, run_arm;

  assign calib_arm = (state_q == S_CALIB);
  assign run_arm   = (state_q == S_RUN);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_trk
    board_calib_tracker u_trk (
      .clock      (clock),
      .reset      (reset),
      .arm_calib  (calib_arm),
      .arm_run    (run_arm),
      .calib_done (calib_done[i]),
      .seen       (seen[i]),
      .lost       (lost[i])
    );
  end

  assign all_seen = &seen;
  assign any_lost = |lost;
`else
  logic unused_calib;
  assign unused_calib = ^calib_done;
  assign any_lost     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    status_d = ST_BUSY;
    unique case (state_q)
      S_RESET: state_d = S_MEM_RST;
`ifdef BOARD_SIM_CALIB_BYPASS_EN
      // Models leave reset one edge before the harness is released.
      S_MEM_RST: if (hold_q == HOLD_END) state_d = S_RUN;
`else
      S_MEM_RST: if (hold_q == HOLD_LAST) state_d = S_CALIB;
      S_CALIB: begin
        if (all_seen) begin
          state_d = S_RUN;
        end else if (CALIB_TIMEOUT != 0 && calib_q == CALIB_LAST) begin
          state_d  = S_FAIL;
          status_d = ST_CALIB_TIMEOUT;
        end
      end
`endif
      S_RUN: begin
        if (dut_fail) begin
          state_d  = S_FAIL;
          status_d = ST_DUT_FAIL;
        end else if (any_lost) begin
          state_d  = S_FAIL;
          status_d = ST_CALIB_LOST;
        end else if (dut_success) begin
          state_d  = S_PASS;
          status_d = ST_PASS;
        end else if (RUN_TIMEOUT != 0 && run_nxt == RUN_LIM) begin
          state_d  = S_FAIL;
          status_d = ST_RUN_TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_RESET;
      status_q      <= ST_BUSY;
      hold_q        <= '0;
      calib_q       <= '0;
      run_q         <= '0;
      ddr_sys_rst_n <= '0;
      dut_reset     <= 1'b1;
      io_success    <= 1'b0;
      io_fail       <= 1'b0;
      io_done       <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= (state_q == S_MEM_RST) ? hold_q + 1'b1 : '0;
      calib_q <= (state_q == S_CALIB) ? calib_q + 1'b1 : '0;
      if (state_q == S_RUN) run_q <= run_nxt;
      if (state_q == S_MEM_RST && hold_q == HOLD_LAST) ddr_sys_rst_n <= '1;
      if (state_d == S_RUN) dut_reset <= 1'b0;
      // Verdict is latched once, on the edge that leaves a live state.
      if (state_q != state_d && (state_d == S_PASS || state_d == S_FAIL)) begin
        status_q   <= status_d;
        io_success <= (state_d == S_PASS);
        io_fail    <= (state_d == S_FAIL);
        io_done    <= 1'b1;
      end
    end
  end

  assign status     = status_q;
  assign run_cycles = run_q;

endmodule

// File: tb/tb_board_sim_ctrl.sv
// tb_board_sim_ctrl: directed scenario table plus reset/timing sequences
// for board_sim_ctrl (2 channels, short hold and timeouts).
module tb_board_sim_ctrl;

  localparam int NCH  = 2;
  localparam int HOLD = 4;
  localparam int CTO  = 64;
  localparam int RTO  = 200;
  localparam int NEV  = 100000;

  typedef struct {
    int d0;
    int d1;
    int succ_at;
    int fail_at;
    int drop_at;
    int exp_status;
    int exp_succ;
    int exp_fail;
    int exp_run;
    int exp_exit;
    int exp_dres;
  } scn_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [NCH-1:0]   calib_done;
  logic             dut_success;
  logic             dut_fail;
  logic [NCH-1:0]   ddr_sys_rst_n;
  logic             dut_reset;
  logic             io_success;
  logic             io_fail;
  logic             io_done;
  logic [2:0]       status;
  logic [31:0]      run_cycles;

  int checks = 0;
  int errors = 0;
  scn_t tbl[8];

  board_sim_ctrl #(
    .NUM_CHANNELS      (NCH),
    .RESET_HOLD_CYCLES (HOLD),
    .CALIB_TIMEOUT     (CTO),
    .RUN_TIMEOUT       (RTO),
    .CNT_W             (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .calib_done    (calib_done),
    .dut_success   (dut_success),
    .dut_fail      (dut_fail),
    .ddr_sys_rst_n (ddr_sys_rst_n),
    .dut_reset     (dut_reset),
    .io_success    (io_success),
    .io_fail       (io_fail),
    .io_done       (io_done),
    .status        (status),
    .run_cycles    (run_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    calib_done  = '0;
    dut_success = 1'b0;
    dut_fail    = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input int idx);
    chk("rst_dut_reset", idx, dut_reset, 1);
    chk("rst_ddr", idx, ddr_sys_rst_n, 0);
    chk("rst_io_success", idx, io_success, 0);
    chk("rst_io_fail", idx, io_fail, 0);
    chk("rst_io_done", idx, io_done, 0);
    chk("rst_status", idx, status, 0);
    chk("rst_run_cycles", idx, run_cycles, 0);
  endtask

  task automatic run_scn(input int idx, input scn_t s);
    int j = 0;
    int r = 0;
    bit fell = 0;
    apply_reset();
    repeat (HOLD + 1) step();
    while (!fell && !io_done && j < 200) begin
      calib_done[0] = (j + 1 >= s.d0);
      calib_done[1] = (j + 1 >= s.d1);
      step();
      j++;
      if (dut_reset == 1'b0) fell = 1;
    end
    chk("calib_exit_edge", idx, j, s.exp_exit);
    chk("dut_reset", idx, dut_reset, s.exp_dres);
    if (fell) begin
      while (!io_done && r < 400) begin
        dut_success   = (r + 1 >= s.succ_at);
        dut_fail      = (r + 1 >= s.fail_at);
        calib_done[0] = (r + 1 != s.drop_at);
        step();
        r++;
      end
    end
    chk("status", idx, status, s.exp_status);
    chk("io_success", idx, io_success, s.exp_succ);
    chk("io_fail", idx, io_fail, s.exp_fail);
    chk("io_done", idx, io_done, 1);
    chk("run_cycles", idx, run_cycles, s.exp_run);
    dut_success = ~dut_success;
    dut_fail    = ~dut_fail;
    calib_done  = '0;
    repeat (5) step();
    chk("frozen_status", idx, status, s.exp_status);
    chk("frozen_run", idx, run_cycles, s.exp_run);
    chk("frozen_success", idx, io_success, s.exp_succ);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          d0  d1   succ fail drop  st ps fl run  exit dres
    tbl[0] = '{10,  40,  101, NEV, NEV,  1, 1, 0, 101, 41,  0};
    tbl[1] = '{10,  NEV, NEV, NEV, NEV,  3, 0, 1, 0,   64,  1};
    tbl[2] = '{3,   3,   NEV, NEV, 20,   4, 0, 1, 20,  4,   0};
    tbl[3] = '{5,   2,   30,  30,  NEV,  2, 0, 1, 30,  6,   0};
    tbl[4] = '{1,   1,   NEV, NEV, NEV,  5, 0, 1, 200, 2,   0};
    tbl[5] = '{2,   7,   15,  NEV, 15,   4, 0, 1, 15,  8,   0};
    tbl[6] = '{4,   4,   NEV, 9,   9,    2, 0, 1, 9,   5,   0};
    tbl[7] = '{1,   1,   1,   NEV, NEV,  1, 1, 0, 1,   2,   0};

    apply_reset();
    reset = 1'b1;
    chk_reset_vals(0);
    reset = 1'b0;

`ifdef BOARD_SIM_CALIB_BYPASS_EN
    begin
      int n = 0;
      while (dut_reset && n < 50) begin
        step();
        n++;
      end
      chk("bypass_run_edge", 0, n, HOLD + 2);
      chk("bypass_ddr", 0, ddr_sys_rst_n, 3);
      dut_success = 1'b1;
      step();
      chk("bypass_status", 0, status, 1);
      chk("bypass_success", 0, io_success, 1);
      chk("bypass_run", 0, run_cycles, 1);
    end
`else
    for (int e = 1; e <= HOLD + 1; e++) begin
      step();
      if (e == HOLD) chk("ddr_before", e, ddr_sys_rst_n, 0);
      if (e == HOLD + 1) chk("ddr_after", e, ddr_sys_rst_n, 3);
    end
    chk("dut_reset_calib", 0, dut_reset, 1);

    for (int i = 0; i < 8; i++) run_scn(i, tbl[i]);

    begin
      int n = 0;
      apply_reset();
      repeat (HOLD + 1) step();
      calib_done = '1;
      while (dut_reset && n < 20) begin
        step();
        n++;
      end
      chk("mid_fall_edge", 1, n, 2);
      repeat (50) step();
      chk("mid_run_cycles", 1, run_cycles, 50);
      reset = 1'b1;
      step();
      chk_reset_vals(1);
      reset = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
